// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per port (CPU, IO/debug).
// The requester drives through master; the arbiter answers through slave.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        stall;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err, stall
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err, stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port 128x32 data memory between the CPU (p0)
// and the IO/debug reader (p1), with address range checking and 1-cycle registered reads.
module dmem_arbiter #(
    parameter int          DEPTH     = 128,
    parameter int          AW        = 7,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    logic        last_gnt;
    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] diff;
    logic        in_range;

    logic        trk_valid;
    logic        trk_read;
    logic        trk_port;
    logic        trk_err;

    // last_gnt = 1 means p1 was served last, so p0 wins the next contention.
    assign gnt0    = ~RESET & p0.req & (~p1.req | last_gnt);
    assign gnt1    = ~RESET & p1.req & (~p0.req | ~last_gnt);
    assign any_gnt = gnt0 | gnt1;

    assign sel_we    = gnt1 ? p1.we    : p0.we;
    assign sel_addr  = gnt1 ? p1.addr  : p0.addr;
    assign sel_wdata = gnt1 ? p1.wdata : p0.wdata;

    // Addresses below the base wrap to huge values, so one unsigned compare covers both bounds.
    assign diff     = sel_addr - BASE_ADDR;
    assign in_range = (diff < SPAN) && (diff[1:0] == 2'b00);

    assign mem_en    = any_gnt & in_range;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = mem_en ? diff[AW+1:2] : '0;
    assign mem_wdata = mem_we ? sel_wdata : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_gnt  <= 1'b1;
            trk_valid <= 1'b0;
            trk_read  <= 1'b0;
            trk_port  <= 1'b0;
            trk_err   <= 1'b0;
        end else begin
            if (any_gnt)
                last_gnt <= gnt1;
            // Track reads (for rvalid) and rejected writes (for the err pulse).
            trk_valid <= any_gnt & (~sel_we | ~in_range);
            trk_read  <= any_gnt & ~sel_we;
            trk_port  <= gnt1;
            trk_err   <= any_gnt & ~in_range;
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.stall  = ~RESET & p0.req & ~gnt0;
    assign p1.stall  = ~RESET & p1.req & ~gnt1;

    assign p0.rvalid = trk_valid & trk_read & ~trk_port;
    assign p1.rvalid = trk_valid & trk_read &  trk_port;
    assign p0.err    = trk_valid & trk_err & ~trk_port;
    assign p1.err    = trk_valid & trk_err &  trk_port;
    assign p0.rdata  = (p0.rvalid & ~trk_err) ? mem_rdata : '0;
    assign p1.rdata  = (p1.rvalid & ~trk_err) ? mem_rdata : '0;

endmodule
